fp_mul_norm_round: RTL and testbench
====================================

Name: fp_mul_norm_round

Overview:
- Pipelined normalize/round/pack stage for the single-precision multiply datapath.
- Directly downstream of the 24x26 Wallace product stage: consumes its 50-bit product z[49:0] together with the sign and biased exponent computed alongside it.
- Produces a packed IEEE-754 single (round-to-nearest-even, no denormals).
- 2-stage pipeline with valid/ready handshake and full back-pressure.

Parameters:
- EXP_W, 10, width of signed two's-complement biased exponent input (must be >= 10).

Ports:
- clk  in  1  clock, all state on rising edge.
- clrn  in  1  synchronous active-low reset.
- in_valid  in  1  product/sign/exp valid this cycle.
- in_ready  out  1  stage accepts input this cycle.
- in_z  in  50  unsigned product; value = in_z / 2^48, range [1,4) for normalized operands.
- in_sign  in  1  result sign.
- in_exp  in  EXP_W  signed biased exponent (ea+eb-127) for value in [1,2).
- out_valid  out  1  out_f holds a result.
- out_ready  in  1  downstream accepts.
- out_f  out  32  packed single {sign, exp[7:0], frac[22:0]}.

Behaviour:
- Reset: synchronous on clrn==0 at clk edge. s1_valid, s2_valid, out_valid = 0; out_f = 0; in_ready = 1 after reset. Reset mid-operation discards all in-flight results; no partial output.
- Transfer rules:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_valid must not depend on in_ready.
- Pipeline: S1 register, then S2 register (drives out_f/out_valid). Latency 2 cycles from input transfer to out_valid with no stalls; throughput 1/cycle.
- Advance:
  - S2 loads when !s2_valid | out_ready.
  - S1 loads when !s1_valid | S2 loads.
  - in_ready = S1 loads (combinational; no bubble when both full and out_ready=1).
  - When out_ready=0 and both stages are full, all registers hold and out_f stays stable.
- S1 (normalize), registered:
  - If in_z[49]=1: m = in_z[49:26], g = in_z[25], st = |in_z[24:0], e = in_exp+1.
  - Else: m = in_z[48:25], g = in_z[24], st = |in_z[23:0], e = in_exp.
  - Sign is passed through.
- S2 (round/pack), registered:
  - RNE: up = g & (st | m[0]); mr = m + up computed 25 bits wide.
  - If mr[24]: mant = 24'h800000, ef = e+1. Else mant = mr[23:0], ef = e.
  - Overflow, signed ef >= 255: out_f = {sign, 8'hFF, 23'h0} (infinity).
  - Underflow, signed ef <= 0: out_f = {sign, 31'h0} (signed zero flush).
  - Otherwise: out_f = {sign, ef[7:0], mant[22:0]}.
- in_z[49:48]==0 (zero operand upstream): treated as a zero result, out_f = {sign, 31'h0}. Rounding is skipped.
- All exponent arithmetic is signed, EXP_W+1 bits wide, so no wrap occurs.

Optional Feature:
- Macro FPNR_STATUS_EN.
- When defined, adds output out_flags[2:0] = {overflow, underflow, inexact}:
  - Registered in S2 alongside out_f; reset 0; held during stall.
  - inexact = g | st, or overflow/underflow forced.
- When undefined, the port and its logic are absent; out_f behaviour is identical in both builds.

Test Plan:
- Reset, then in_z=50'h1000000000000, sign 0, exp 127, out_ready=1 -> out_f=32'h3F800000, out_valid exactly 2 cycles after transfer.
- in_z=50'h2000000000000, exp 127 -> 32'h40000000. in_z=50'h1000001000000 (tie, lsb 0) -> 32'h3F800000. in_z=50'h1000003000000 (tie, lsb 1) -> 32'h3F800002.
- Round carry-out: in_z=50'h1FFFFFF000000, exp 127 -> 32'h40000000. Sign 1 on the same input -> 32'hC0000000.
- Exponent limits: in_z=50'h2000000000000, exp 254 -> 32'h7F800000. exp 0 with in_z=50'h1000000000000, sign 1 -> 32'h80000000. Negative exp -5 -> 32'h80000000 or 32'h00000000 per sign. With FPNR_STATUS_EN, flags read 3'b101 and 3'b011 respectively.
- Back-pressure:
  - Stream 5 back-to-back inputs, out_ready=0 for cycles 3-6 -> in_ready drops once both stages are full, out_f stable while stalled.
  - All 5 results emerge in order, none lost or duplicated.
  - 1/cycle resumes after release.
- Drop clrn for 1 cycle with 2 results in flight -> next cycle out_valid=0, out_f=0, in_ready=1; the next input yields its correct result 2 cycles later.

Source files
------------

// File: rtl/fp_mul_norm_round.sv
// Normalize/round/pack stage for the single-precision multiplier: 2-stage valid/ready pipeline,
// round-to-nearest-even, no denormals. Define FPNR_STATUS_EN to add out_flags.
module fp_mul_norm_round #(
  parameter int EXP_W = 10
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [49:0]      in_z,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef FPNR_STATUS_EN
  output logic [2:0]       out_flags,
`endif
  output logic [31:0]      out_f
);

  localparam logic signed [EXP_W:0] EXP_MAX = (EXP_W+1)'(255);
  localparam logic signed [EXP_W:0] EXP_ONE = (EXP_W+1)'(1);

  logic s1_load, s2_load;
  logic s1_valid, s2_valid;

  // S1 state
  logic                    s1_sign;
  logic                    s1_zero;
  logic [23:0]             s1_m;
  logic                    s1_g;
  logic                    s1_st;
  logic signed [EXP_W:0]   s1_e;

  // S1 next-state
  logic                    n1_zero;
  logic [23:0]             n1_m;
  logic                    n1_g;
  logic                    n1_st;
  logic signed [EXP_W:0]   n1_e;
  logic signed [EXP_W:0]   exp_ext;

  // S2 next-state
  logic                    up;
  logic [24:0]             mr;
  logic [22:0]             frac;
  logic signed [EXP_W:0]   ef;
  logic                    ovf, unf;
  logic [31:0]             n2_f;
  logic [2:0]              n2_flags;
  logic                    mr_unused;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  assign exp_ext = {in_exp[EXP_W-1], in_exp};

  always_comb begin
    n1_zero = (in_z[49:48] == 2'b00);
    if (in_z[49]) begin
      n1_m  = in_z[49:26];
      n1_g  = in_z[25];
      n1_st = |in_z[24:0];
      n1_e  = exp_ext + EXP_ONE;
    end else begin
      n1_m  = in_z[48:25];
      n1_g  = in_z[24];
      n1_st = |in_z[23:0];
      n1_e  = exp_ext;
    end
  end

  // A carry out of the rounder leaves mr = 2^24, so the fraction becomes zero and ef bumps.
  assign up        = s1_g & (s1_st | s1_m[0]);
  assign mr        = {1'b0, s1_m} + {24'h0, up};
  assign frac      = mr[24] ? 23'h0 : mr[22:0];
  assign ef        = s1_e + {{EXP_W{1'b0}}, mr[24]};
  assign ovf       = (ef >= EXP_MAX);
  assign unf       = ef[EXP_W] || (ef == '0);
  assign mr_unused = mr[23];

  always_comb begin
    n2_f     = {s1_sign, ef[7:0], frac};
    n2_flags = {2'b00, s1_g | s1_st};
    if (s1_zero) begin
      n2_f     = {s1_sign, 31'h0};
      n2_flags = 3'b000;
    end else if (ovf) begin
      n2_f     = {s1_sign, 8'hFF, 23'h0};
      n2_flags = 3'b101;
    end else if (unf) begin
      n2_f     = {s1_sign, 31'h0};
      n2_flags = 3'b011;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_m     <= '0;
      s1_g     <= 1'b0;
      s1_st    <= 1'b0;
      s1_e     <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_zero <= n1_zero;
        s1_m    <= n1_m;
        s1_g    <= n1_g;
        s1_st   <= n1_st;
        s1_e    <= n1_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s2_valid <= 1'b0;
      out_f    <= 32'h0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_f <= n2_f;
    end
  end

`ifdef FPNR_STATUS_EN
  always_ff @(posedge clk) begin
    if (!clrn) begin
      out_flags <= 3'b000;
    end else if (s2_load && s1_valid) begin
      out_flags <= n2_flags;
    end
  end
`else
  logic [2:0] flags_unused;
  assign flags_unused = n2_flags;
`endif

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Scoreboard bench for fp_mul_norm_round: directed cases, back-pressure, mid-flight reset and
// a random stream. Expected {flags, out_f} are queued when an input transfers.
module tb_fp_mul_norm_round;
  localparam int EXP_W = 10;

  logic             clk = 1'b0;
  logic             clrn;
  logic             in_valid;
  logic             in_ready;
  logic [49:0]      in_z;
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_f;
`ifdef FPNR_STATUS_EN
  logic [2:0]       out_flags;
`endif

  always #5 clk = ~clk;

  fp_mul_norm_round #(.EXP_W(EXP_W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_sign   (in_sign),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef FPNR_STATUS_EN
    .out_flags (out_flags),
`endif
    .out_f     (out_f)
  );

  int checks   = 0;
  int failures = 0;

  logic [34:0] sb[$];
  logic [34:0] cur_exp;
  logic        in_fire, out_fire;
  logic        smp_out_valid, smp_in_ready;
  logic [31:0] smp_out_f;
  int          n_out = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] model(input logic [49:0] z, input logic s, input int e);
    longint unsigned zz, mant, rem, half;
    int sh, ee;
    zz = 64'(z);
    if (z[49:48] == 2'b00) return {3'b000, s, 31'h0};
    sh   = z[49] ? 26 : 25;
    ee   = e + sh - 25;
    mant = zz >> sh;
    rem  = zz - (mant << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant++;
    if (mant == (64'd1 << 24)) begin
      mant = mant >> 1;
      ee++;
    end
    if (ee >= 255) return {3'b101, s, 8'hFF, 23'h0};
    if (ee <= 0) return {3'b011, s, 31'h0};
    return {2'b00, rem != 0, s, ee[7:0], mant[22:0]};
  endfunction

  // Sample one cycle just before its rising edge, run the scoreboard, then step past the edge.
  task automatic tick();
    logic [34:0] e;
    @(negedge clk);
    #4;
    smp_out_valid = out_valid;
    smp_in_ready  = in_ready;
    smp_out_f     = out_f;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (in_fire && clrn) sb.push_back(cur_exp);
    if (out_fire && clrn) begin
      n_out++;
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_f), 64'hDEAD);
      end else begin
        e = sb.pop_front();
        check("out_f", 64'(out_f), 64'(e[31:0]));
`ifdef FPNR_STATUS_EN
        check("out_flags", 64'(out_flags), 64'(e[34:32]));
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [49:0] z, input logic s, input int e, input logic [34:0] x);
    in_z    = z;
    in_sign = s;
    in_exp  = e[EXP_W-1:0];
    cur_exp = x;
  endtask

  // Holds in_valid high until accepted; leaves it high so calls chain back-to-back.
  task automatic send(input logic [49:0] z, input logic s, input int e, input logic [34:0] x);
    int n;
    set_in(z, s, e, x);
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!in_fire && n < 50);
    if (!in_fire) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    clrn     = 1'b0;
    in_valid = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
    sb.delete();
  endtask

  initial begin
    logic [49:0] z;
    logic        s;
    int          e, k, idx, fires_after, pend;
    logic        saw_ready_low, prev_stall;
    logic [31:0] prev_f;

    in_z      = '0;
    in_sign   = 1'b0;
    in_exp    = '0;
    out_ready = 1'b1;
    cur_exp   = '0;
    do_reset();

    tick();
    check("rst_out_valid", 64'(smp_out_valid), 64'd0);
    check("rst_out_f", 64'(smp_out_f), 64'd0);
    check("rst_in_ready", 64'(smp_in_ready), 64'd1);

    // First transfer: out_valid exactly two edges later.
    send(50'h1000000000000, 1'b0, 127, {3'b000, 32'h3F800000});
    in_valid = 1'b0;
    tick();
    check("lat_cycle1_valid", 64'(smp_out_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(smp_out_valid), 64'd1);
    drain();

    send(50'h2000000000000, 1'b0, 127, {3'b000, 32'h40000000});
    send(50'h1000001000000, 1'b0, 127, {3'b001, 32'h3F800000});
    send(50'h1000003000000, 1'b0, 127, {3'b001, 32'h3F800002});
    send(50'h1FFFFFF000000, 1'b0, 127, {3'b001, 32'h40000000});
    send(50'h1FFFFFF000000, 1'b1, 127, {3'b001, 32'hC0000000});
    send(50'h2000000000000, 1'b0, 254, {3'b101, 32'h7F800000});
    send(50'h1000000000000, 1'b1, 0,   {3'b011, 32'h80000000});
    send(50'h1000000000000, 1'b1, -5,  {3'b011, 32'h80000000});
    send(50'h1000000000000, 1'b0, -5,  {3'b011, 32'h00000000});
    send(50'h0,             1'b1, 127, {3'b000, 32'h80000000});
    drain();

    // Back-pressure: 5 inputs, out_ready low for cycles 3..6.
    idx           = 0;
    fires_after   = 0;
    saw_ready_low = 1'b0;
    prev_stall    = 1'b0;
    prev_f        = '0;
    for (k = 0; k < 20; k++) begin
      out_ready = !(k >= 3 && k <= 6);
      if (idx < 5) begin
        z = 50'h1000000000000 | (50'(idx + 1) << 30) | 50'(idx * 3);
        set_in(z, idx[0], 100 + idx, model(z, idx[0], 100 + idx));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (in_fire) idx++;
      if (k >= 3 && k <= 6 && !smp_in_ready) saw_ready_low = 1'b1;
      if (prev_stall) check("stall_stable", 64'(smp_out_f), 64'(prev_f));
      prev_stall = smp_out_valid && !out_ready;
      prev_f     = smp_out_f;
      if (k >= 7 && k <= 10 && out_fire) fires_after++;
    end
    check("bp_ready_dropped", 64'(saw_ready_low), 64'd1);
    check("bp_all_sent", 64'(idx), 64'd5);
    check("bp_resume_rate", 64'(fires_after), 64'd4);
    out_ready = 1'b1;
    drain();

    // Mid-flight reset discards both results.
    send(50'h2000000000000, 1'b0, 130, model(50'h2000000000000, 1'b0, 130));
    send(50'h1800000000000, 1'b1, 130, model(50'h1800000000000, 1'b1, 130));
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clrn      = 1'b0;
    tick();
    clrn      = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    tick();
    check("midrst_out_valid", 64'(smp_out_valid), 64'd0);
    check("midrst_out_f", 64'(smp_out_f), 64'd0);
    check("midrst_in_ready", 64'(smp_in_ready), 64'd1);
    send(50'h1000000000000, 1'b0, 127, {3'b000, 32'h3F800000});
    in_valid = 1'b0;
    tick();
    check("midrst_lat1", 64'(smp_out_valid), 64'd0);
    tick();
    check("midrst_lat2", 64'(smp_out_valid), 64'd1);
    drain();

    // Random stream with random back-pressure.
    pend = 0;
    in_valid = 1'b0;
    for (k = 0; k < 600 && pend < 60; k++) begin
      if (!in_valid && $urandom_range(0, 9) < 8) begin
        z = {$urandom_range(1, 3), 16'($urandom), $urandom};
        if ($urandom_range(0, 15) == 0) z = '0;
        if ($urandom_range(0, 3) == 0) z[23:0] = '0;
        s = 1'($urandom);
        e = int'($urandom_range(0, 290)) - 20;
        set_in(z, s, e, model(z, s, e));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      if (in_fire) begin
        in_valid = 1'b0;
        pend++;
      end
    end
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
